aes_state_io: RTL and testbench

- Block-level load/unload sequencer for the AES 4x4 state matrix.
- Load side: accepts a 128-bit block over a valid/ready handshake and writes it into the state matrix one column per cycle.
- Core side: pulses the round core to start and waits for its done strobe.
- Unload side: reads the four columns back, reassembles the 128-bit result and presents it over a valid/ready handshake.
- Sits between the top-level data interface and the matrix storage, so it drives the matrix write and read ports.

---
 rtl/aes_state_io.sv | 160 ++++++++++++++++
 tb/tb_aes_state_io.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_state_io.sv
// Load/unload sequencer between the 128-bit block interface and the AES state matrix.
// Define AES_STATE_IO_VERIFY_EN to add a post-load read-back check with a sticky load_err flag.
`timescale 1ns / 1ps
module aes_state_io #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMEOUT_W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [31:0]  mat_col,
  output logic [1:0]   mat_in_idx,
  output logic         mat_in_row_col,
  output logic         mat_we,
  output logic [1:0]   mat_out_idx,
  output logic         mat_out_row_col,
  input  logic [31:0]  mat_rd_data,
  output logic         core_start,
  input  logic         core_done,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic         timeout
`ifdef AES_STATE_IO_VERIFY_EN
  ,
  output logic         load_err
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StVerify,
    StStart,
    StWait,
    StUnload,
    StOut
  } state_e;

  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);
  // Last wait-counter value before giving up; WAIT lasts at most TIMEOUT_CYCLES cycles.
  localparam logic [TIMEOUT_W-1:0] WaitLast =
      TimeoutEn ? TIMEOUT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_e                 st_q;
  logic [1:0]             cnt_q;
  logic [TIMEOUT_W-1:0]   wait_q;
  logic [127:0]           blk_q;
  logic [127:0]           out_block_q;
  logic                   timeout_q;
`ifdef AES_STATE_IO_VERIFY_EN
  logic                   load_err_q;
`endif

  function automatic logic [31:0] col_sel(input logic [127:0] b, input logic [1:0] i);
    logic [31:0] c;
    unique case (i)
      2'd0: c = b[127:96];
      2'd1: c = b[95:64];
      2'd2: c = b[63:32];
      default: c = b[31:0];
    endcase
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= StIdle;
      cnt_q       <= '0;
      wait_q      <= '0;
      blk_q       <= '0;
      out_block_q <= '0;
      timeout_q   <= 1'b0;
`ifdef AES_STATE_IO_VERIFY_EN
      load_err_q  <= 1'b0;
`endif
    end else begin
      case (st_q)
        StIdle: begin
          if (in_valid) begin
            blk_q <= in_block;
            cnt_q <= '0;
            st_q  <= StLoad;
          end
        end
        StLoad: begin
          cnt_q <= cnt_q + 2'd1;  // wraps to 0 after column 3
          if (cnt_q == 2'd3) begin
`ifdef AES_STATE_IO_VERIFY_EN
            st_q <= StVerify;
`else
            st_q <= StStart;
`endif
          end
        end
`ifdef AES_STATE_IO_VERIFY_EN
        StVerify: begin
          if (mat_rd_data != col_sel(blk_q, cnt_q)) load_err_q <= 1'b1;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) st_q <= StStart;
        end
`endif
        StStart: begin
          wait_q <= '0;
          st_q   <= StWait;
        end
        StWait: begin
          // core_done takes priority over a timeout reached in the same cycle
          if (core_done) begin
            cnt_q <= '0;
            st_q  <= StUnload;
          end else if (TimeoutEn && (wait_q == WaitLast)) begin
            timeout_q <= 1'b1;
            st_q      <= StIdle;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StUnload: begin
          unique case (cnt_q)
            2'd0: out_block_q[127:96] <= mat_rd_data;
            2'd1: out_block_q[95:64]  <= mat_rd_data;
            2'd2: out_block_q[63:32]  <= mat_rd_data;
            default: out_block_q[31:0] <= mat_rd_data;
          endcase
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) st_q <= StOut;
        end
        StOut: begin
          if (out_ready) st_q <= StIdle;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  // Moore decode: every output depends only on registered state.
  always_comb begin
    in_ready    = (st_q == StIdle);
    busy        = (st_q != StIdle);
    mat_we      = (st_q == StLoad);
    mat_in_idx  = mat_we ? cnt_q : 2'd0;
    mat_col     = mat_we ? col_sel(blk_q, cnt_q) : 32'd0;
    mat_out_idx = ((st_q == StUnload) || (st_q == StVerify)) ? cnt_q : 2'd0;
    core_start  = (st_q == StStart);
    out_valid   = (st_q == StOut);
  end

  assign mat_in_row_col  = 1'b1;
  assign mat_out_row_col = 1'b1;
  assign out_block       = out_block_q;
  assign timeout         = timeout_q;
`ifdef AES_STATE_IO_VERIFY_EN
  assign load_err        = load_err_q;
`endif

endmodule

// File: tb/tb_aes_state_io.sv
// Bench for aes_state_io: matrix and round-core models, directed and random transactions.
`timescale 1ns / 1ps
module tb_aes_state_io;

`ifdef AES_STATE_IO_VERIFY_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 5;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [31:0]  mat_col;
  logic [1:0]   mat_in_idx;
  logic         mat_in_row_col;
  logic         mat_we;
  logic [1:0]   mat_out_idx;
  logic         mat_out_row_col;
  logic [31:0]  mat_rd_data;
  logic         core_start;
  logic         core_done;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;
  logic         timeout;
  logic         load_err;

  // Second instance with a timeout and a core that never answers.
  logic         to_in_ready, to_mat_in_row_col, to_mat_we, to_mat_out_row_col;
  logic         to_core_start, to_out_valid, to_busy, to_timeout, to_load_err;
  logic [31:0]  to_mat_col;
  logic [1:0]   to_mat_in_idx, to_mat_out_idx;
  logic [127:0] to_out_block;

  always #5 clk = ~clk;

  aes_state_io #(.TIMEOUT_CYCLES(0), .TIMEOUT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .mat_col(mat_col), .mat_in_idx(mat_in_idx), .mat_in_row_col(mat_in_row_col),
    .mat_we(mat_we), .mat_out_idx(mat_out_idx), .mat_out_row_col(mat_out_row_col),
    .mat_rd_data(mat_rd_data), .core_start(core_start), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy),
    .timeout(timeout)
`ifdef AES_STATE_IO_VERIFY_EN
    , .load_err(load_err)
`endif
  );

  aes_state_io #(.TIMEOUT_CYCLES(8), .TIMEOUT_W(16)) dut_to (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(to_in_ready), .in_block(in_block),
    .mat_col(to_mat_col), .mat_in_idx(to_mat_in_idx), .mat_in_row_col(to_mat_in_row_col),
    .mat_we(to_mat_we), .mat_out_idx(to_mat_out_idx), .mat_out_row_col(to_mat_out_row_col),
    .mat_rd_data(32'd0), .core_start(to_core_start), .core_done(1'b0),
    .out_valid(to_out_valid), .out_ready(1'b1), .out_block(to_out_block), .busy(to_busy),
    .timeout(to_timeout)
`ifdef AES_STATE_IO_VERIFY_EN
    , .load_err(to_load_err)
`endif
  );

`ifndef AES_STATE_IO_VERIFY_EN
  assign load_err    = 1'b0;
  assign to_load_err = 1'b0;
`endif

  // Matrix model: column writes from the DUT, whole-state writes from the core model.
  logic [31:0]  mem [4];
  logic         core_wr;
  logic [127:0] core_res;
  logic         corrupt2;
  assign mat_rd_data = (corrupt2 && mat_out_idx == 2'd2) ? (mem[2] ^ 32'hdead_beef)
                                                         : mem[mat_out_idx];

  logic [33:0] wr_log [$];
  int cyc = 0, acc_cyc = 0, start_cyc = 0, done_cyc = 0, ov_rise_cyc = 0, to_ov_cnt = 0;
  logic ov_d = 1'b0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    ov_d <= out_valid;
    if (core_wr) begin
      mem[0] <= core_res[127:96];
      mem[1] <= core_res[95:64];
      mem[2] <= core_res[63:32];
      mem[3] <= core_res[31:0];
    end else if (mat_we) begin
      mem[mat_in_idx] <= mat_col;
    end
    if (mat_we) wr_log.push_back({mat_in_idx, mat_col});
    if (!reset && in_valid && in_ready) acc_cyc <= cyc;
    if (!reset && core_start) start_cyc <= cyc;
    if (core_done) done_cyc <= cyc;
    if (out_valid && !ov_d) ov_rise_cyc <= cyc;
    if (to_out_valid) to_ov_cnt <= to_ov_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] blk);
    for (int n = 0; n < 60 && !in_ready; n++) tick();
    check("in_ready_before_send", in_ready, 1);
    in_block = blk;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_core(input logic [127:0] res, input int delay);
    for (int n = 0; n < 40 && !core_start; n++) tick();
    check("core_start_seen", core_start, 1);
    corrupt2 = 1'b0;
    tick();
    check("core_start_one_cycle", core_start, 0);
    for (int n = 0; n < delay; n++) begin
      check("busy_while_waiting", {in_ready, busy}, 2'b01);
      tick();
    end
    core_res = res;
    core_wr  = 1'b1;
    tick();
    core_wr   = 1'b0;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic do_txn(input logic [127:0] blk, input logic [127:0] res, input int delay,
                        input int bp);
    int base;
    base = wr_log.size();
    send(blk);
    run_core(res, delay);
    for (int n = 0; n < 20 && !out_valid; n++) tick();
    check("out_valid_seen", out_valid, 1);
    for (int n = 0; n < bp; n++) begin
      check("bp_hold", {out_valid, in_ready, out_block}, {1'b1, 1'b0, res});
      tick();
    end
    check("out_block", out_block, res);
    check("start_latency", start_cyc - acc_cyc, LAT);
    check("done_to_valid", ov_rise_cyc - done_cyc, 5);
    check("write_count", wr_log.size() - base, 4);
    for (int i = 0; i < 4; i++)
      check("write_col", wr_log[base+i], {2'(i), 32'(blk >> (32 * (3 - i)))});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_after_out", {in_ready, busy, out_valid}, 3'b100);
    check("out_block_kept", out_block, res);
  endtask

  initial begin
    logic [127:0] blk, res;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_block  = '0;
    core_done = 1'b0;
    core_wr   = 1'b0;
    core_res  = '0;
    out_ready = 1'b0;
    corrupt2  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_ctrl", {busy, mat_we, core_start, out_valid, timeout, load_err}, 6'b0);
    check("reset_const", {mat_in_row_col, mat_out_row_col}, 2'b11);
    check("reset_idx_col", {mat_in_idx, mat_out_idx, mat_col}, 36'd0);
    check("reset_out_block", out_block, 128'd0);
    check("reset_to_timeout", to_timeout, 0);

    // Directed load/unload with 20 cycles of back-pressure.
    do_txn(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
           10, 20);
    check("to_timeout_set", {to_timeout, to_in_ready, to_busy}, 3'b110);
    check("to_no_output", to_ov_cnt, 0);

    for (int t = 0; t < 6; t++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      res = blk ^ {$urandom, $urandom, $urandom, $urandom};
      do_txn(blk, res, int'($urandom_range(0, 12)), int'($urandom_range(0, 5)));
    end
    check("to_timeout_sticky", to_timeout, 1);
    check("to_no_output_end", to_ov_cnt, 0);
    check("no_load_err", load_err, 0);

    // Reset during the second LOAD cycle.
    send({$urandom, $urandom, $urandom, $urandom});
    tick();
    check("in_load", {mat_we, mat_in_idx}, 3'b101);
    reset = 1'b1;
    tick();
    check("mid_reset", {mat_we, busy, core_start}, 3'b000);
    reset = 1'b0;
    check("mid_reset_ready", in_ready, 1);
    check("mid_reset_to_cleared", to_timeout, 0);
    blk = {$urandom, $urandom, $urandom, $urandom};
    do_txn(blk, ~blk, 3, 1);

`ifdef AES_STATE_IO_VERIFY_EN
    check("load_err_before", load_err, 0);
    corrupt2 = 1'b1;
    blk = {$urandom, $urandom, $urandom, $urandom};
    do_txn(blk, blk ^ 128'h5a, 2, 0);
    check("load_err_set", load_err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
